// File: rtl/detection_collector.sv
// Collects positive window verdicts, rescales them to original-frame coordinates and queues them for the host.
// Optional DETECTION_MERGE_EN: drop detections within MERGE_DIST of the last one pushed in the frame.
module detection_collector #(
  parameter int DATA_WIDTH_12                = 12,
  parameter int FIFO_DEPTH                   = 8,
  parameter int SCALE_X_Q8                   = 256,
  parameter int SCALE_Y_Q8                   = 256,
  parameter int FRAME_ORIGINAL_CAMERA_WIDTH  = 10,
  parameter int FRAME_ORIGINAL_CAMERA_HEIGHT = 10,
  parameter int MERGE_DIST                   = 1
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     inspect_done,
  input  logic                     candidate,
  input  logic [DATA_WIDTH_12-1:0] resize_x,
  input  logic [DATA_WIDTH_12-1:0] resize_y,
  input  logic                     frame_end,
  input  logic                     det_ready,
  output logic                     o_det_valid,
  output logic [DATA_WIDTH_12-1:0] o_det_x,
  output logic [DATA_WIDTH_12-1:0] o_det_y,
  output logic                     o_frame_done,
  output logic [DATA_WIDTH_12-1:0] o_frame_count,
  output logic                     o_overflow
);

  localparam int DW = DATA_WIDTH_12;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [DW-1:0] MAX_X   = DW'(FRAME_ORIGINAL_CAMERA_WIDTH - 1);
  localparam logic [DW-1:0] MAX_Y   = DW'(FRAME_ORIGINAL_CAMERA_HEIGHT - 1);
  localparam logic [DW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SCALE, PUSH} state_t;

  state_t          state_q, state_d;
  logic            inspect_done_q;
  logic [DW-1:0]   cap_x_q, cap_x_d, cap_y_q, cap_y_d;
  logic            pend_valid_q, pend_valid_d;
  logic [DW-1:0]   pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [19:0]     px_q, px_d, py_q, py_d;
  logic [DW-1:0]   cnt_q, cnt_d, frame_count_q, frame_count_d;
  logic            frame_done_q, frame_done_d;
  logic            overflow_q, overflow_d;
  logic            close_req_q, close_req_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]   mem_x_q [FIFO_DEPTH];
  logic [DW-1:0]   mem_y_q [FIFO_DEPTH];

  logic            ev, cand_event, empty, full, pop, push, merge_hit, close_fire;
  logic [DW-1:0]   scaled_x, scaled_y, det_x, det_y;

  assign ev         = inspect_done && !inspect_done_q;
  assign cand_event = ev && candidate;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && det_ready;

  assign scaled_x = DW'(px_q >> 8);
  assign scaled_y = DW'(py_q >> 8);
  assign det_x    = (scaled_x > MAX_X) ? MAX_X : scaled_x;
  assign det_y    = (scaled_y > MAX_Y) ? MAX_Y : scaled_y;

  // Close only when nothing can still reach the FIFO this frame.
  assign close_fire = close_req_q && (state_q == IDLE) && !pend_valid_q && !ev;

`ifdef DETECTION_MERGE_EN
  localparam logic [DW-1:0] MERGE_R = DW'(MERGE_DIST);
  logic            hist_valid_q, hist_valid_d;
  logic [DW-1:0]   hist_x_q, hist_x_d, hist_y_q, hist_y_d;
  logic [DW-1:0]   dist_x, dist_y;

  assign dist_x    = (det_x >= hist_x_q) ? det_x - hist_x_q : hist_x_q - det_x;
  assign dist_y    = (det_y >= hist_y_q) ? det_y - hist_y_q : hist_y_q - det_y;
  assign merge_hit = hist_valid_q && (dist_x <= MERGE_R) && (dist_y <= MERGE_R);
`else
  logic unused_cfg;
  assign unused_cfg = (MERGE_DIST != 0);
  assign merge_hit  = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cap_x_d       = cap_x_q;
    cap_y_d       = cap_y_q;
    pend_valid_d  = pend_valid_q;
    pend_x_d      = pend_x_q;
    pend_y_d      = pend_y_q;
    px_d          = px_q;
    py_d          = py_q;
    cnt_d         = cnt_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    overflow_d    = overflow_q;
    push          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          cap_x_d      = pend_x_q;
          cap_y_d      = pend_y_q;
          pend_valid_d = 1'b0;
          state_d      = SCALE;
          // A same-cycle event refills the slot just vacated.
          if (cand_event) begin
            pend_valid_d = 1'b1;
            pend_x_d     = resize_x;
            pend_y_d     = resize_y;
          end
        end else if (cand_event) begin
          cap_x_d = resize_x;
          cap_y_d = resize_y;
          state_d = SCALE;
        end
      end
      SCALE: begin
        px_d    = 20'(cap_x_q) * 20'(SCALE_X_Q8);
        py_d    = 20'(cap_y_q) * 20'(SCALE_Y_Q8);
        state_d = PUSH;
      end
      PUSH: begin
        state_d = IDLE;
        if (!merge_hit) begin
          if (!full || pop) push = 1'b1;
          else              overflow_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cand_event && (state_q != IDLE)) begin
      if (pend_valid_q) begin
        overflow_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_x_d     = resize_x;
        pend_y_d     = resize_y;
      end
    end

    if (push && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;

    if (close_fire) begin
      frame_done_d  = 1'b1;
      frame_count_d = cnt_d;
      cnt_d         = '0;
    end
    close_req_d = close_fire ? 1'b0 : (close_req_q || frame_end);

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);

`ifdef DETECTION_MERGE_EN
    hist_valid_d = hist_valid_q;
    hist_x_d     = hist_x_q;
    hist_y_d     = hist_y_q;
    if (push) begin
      hist_valid_d = 1'b1;
      hist_x_d     = det_x;
      hist_y_d     = det_y;
    end
    if (close_fire) hist_valid_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state_q        <= IDLE;
      inspect_done_q <= 1'b0;
      cap_x_q        <= '0;
      cap_y_q        <= '0;
      pend_valid_q   <= 1'b0;
      pend_x_q       <= '0;
      pend_y_q       <= '0;
      px_q           <= '0;
      py_q           <= '0;
      cnt_q          <= '0;
      frame_count_q  <= '0;
      frame_done_q   <= 1'b0;
      overflow_q     <= 1'b0;
      close_req_q    <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
    end else begin
      state_q        <= state_d;
      inspect_done_q <= inspect_done;
      cap_x_q        <= cap_x_d;
      cap_y_q        <= cap_y_d;
      pend_valid_q   <= pend_valid_d;
      pend_x_q       <= pend_x_d;
      pend_y_q       <= pend_y_d;
      px_q           <= px_d;
      py_q           <= py_d;
      cnt_q          <= cnt_d;
      frame_count_q  <= frame_count_d;
      frame_done_q   <= frame_done_d;
      overflow_q     <= overflow_d;
      close_req_q    <= close_req_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
    end
  end

`ifdef DETECTION_MERGE_EN
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      hist_valid_q <= 1'b0;
      hist_x_q     <= '0;
      hist_y_q     <= '0;
    end else begin
      hist_valid_q <= hist_valid_d;
      hist_x_q     <= hist_x_d;
      hist_y_q     <= hist_y_d;
    end
  end
`endif

  // Storage has no reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_fpga) begin
    if (push) begin
      mem_x_q[wr_ptr_q[AW-1:0]] <= det_x;
      mem_y_q[wr_ptr_q[AW-1:0]] <= det_y;
    end
  end

  assign o_det_valid   = !empty;
  assign o_det_x       = empty ? '0 : mem_x_q[rd_ptr_q[AW-1:0]];
  assign o_det_y       = empty ? '0 : mem_y_q[rd_ptr_q[AW-1:0]];
  assign o_frame_done  = frame_done_q;
  assign o_frame_count = frame_count_q;
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_detection_collector.sv
// Directed bench for detection_collector: scale 2.0 x 1.5, 20x16 frame, 4-entry FIFO, merge radius 2.
`timescale 1ns/1ps
module tb_detection_collector;

  logic        clk_fpga = 1'b0;
  logic        reset_fpga;
  logic        inspect_done;
  logic        candidate;
  logic [11:0] resize_x;
  logic [11:0] resize_y;
  logic        frame_end;
  logic        det_ready;
  logic        o_det_valid;
  logic [11:0] o_det_x;
  logic [11:0] o_det_y;
  logic        o_frame_done;
  logic [11:0] o_frame_count;
  logic        o_overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk_fpga = ~clk_fpga;

  detection_collector #(
    .DATA_WIDTH_12               (12),
    .FIFO_DEPTH                  (4),
    .SCALE_X_Q8                  (512),
    .SCALE_Y_Q8                  (384),
    .FRAME_ORIGINAL_CAMERA_WIDTH (20),
    .FRAME_ORIGINAL_CAMERA_HEIGHT(16),
    .MERGE_DIST                  (2)
  ) dut (
    .clk_fpga     (clk_fpga),
    .reset_fpga   (reset_fpga),
    .inspect_done (inspect_done),
    .candidate    (candidate),
    .resize_x     (resize_x),
    .resize_y     (resize_y),
    .frame_end    (frame_end),
    .det_ready    (det_ready),
    .o_det_valid  (o_det_valid),
    .o_det_x      (o_det_x),
    .o_det_y      (o_det_y),
    .o_frame_done (o_frame_done),
    .o_frame_count(o_frame_count),
    .o_overflow   (o_overflow)
  );

  task automatic tick();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic do_reset();
    reset_fpga   = 1'b1;
    inspect_done = 1'b0;
    candidate    = 1'b0;
    resize_x     = '0;
    resize_y     = '0;
    frame_end    = 1'b0;
    det_ready    = 1'b0;
    tick();
    tick();
    reset_fpga = 1'b0;
  endtask

  // Returns 1 ns after the edge that sampled the event.
  task automatic pulse_event(input logic cand, input logic [11:0] x, input logic [11:0] y);
    tick();
    inspect_done = 1'b1;
    candidate    = cand;
    resize_x     = x;
    resize_y     = y;
    tick();
    inspect_done = 1'b0;
    candidate    = 1'b0;
  endtask

  task automatic pulse_frame_end();
    tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic pop_one();
    det_ready = 1'b1;
    tick();
    det_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({o_det_valid, o_det_x, o_det_y, o_frame_done, o_frame_count, o_overflow} !== '0)
        begin
          errors++;
          $display("FAIL reset_idle cyc%0d: got v=%b x=%0d y=%0d done=%b cnt=%0d ovf=%b, want all 0",
                   i, o_det_valid, o_det_x, o_det_y, o_frame_done, o_frame_count, o_overflow);
        end
      tick();
    end
    $display("test_reset: %0d idle cycles checked", 10);
  endtask

  task automatic test_latency_hold();
    do_reset();
    pulse_event(1'b1, 12'd4, 12'd5);
    checks++;
    if (o_det_valid !== 1'b0) begin
      errors++; $display("FAIL lat_n1: valid=%b want 0", o_det_valid);
    end
    tick();
    checks++;
    if (o_det_valid !== 1'b0) begin
      errors++; $display("FAIL lat_n2: valid=%b want 0", o_det_valid);
    end
    tick();
    checks++;
    if (o_det_valid !== 1'b1 || o_det_x !== 12'd8 || o_det_y !== 12'd7) begin
      errors++; $display("FAIL lat_n3: v=%b x=%0d y=%0d want v=1 x=8 y=7", o_det_valid, o_det_x, o_det_y);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o_det_valid !== 1'b1 || o_det_x !== 12'd8 || o_det_y !== 12'd7) begin
        errors++; $display("FAIL hold%0d: v=%b x=%0d y=%0d want v=1 x=8 y=7", i, o_det_valid, o_det_x, o_det_y);
      end
    end
    pop_one();
    checks++;
    if (o_det_valid !== 1'b0) begin
      errors++; $display("FAIL after_pop: valid=%b want 0", o_det_valid);
    end
    $display("test_latency_hold: event (4,5) -> (%0d,%0d) expected (8,7)", 8, 7);
  endtask

  task automatic test_non_candidate_close();
    int n;
    do_reset();
    pulse_event(1'b0, 12'd3, 12'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (o_det_valid !== 1'b0) begin
        errors++; $display("FAIL noncand_valid%0d: valid=%b want 0", i, o_det_valid);
      end
    end
    pulse_frame_end();
    n = 0;
    while (o_frame_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (o_frame_done !== 1'b1) begin
      errors++; $display("FAIL noncand_done: frame_done=%b want 1 within 20 cycles", o_frame_done);
    end else begin
      checks++;
      if (o_frame_count !== 12'd0) begin
        errors++; $display("FAIL noncand_count: count=%0d want 0", o_frame_count);
      end
      tick();
      checks++;
      if (o_frame_done !== 1'b0) begin
        errors++; $display("FAIL noncand_pulse: frame_done=%b want 0 one cycle later", o_frame_done);
      end
    end
    $display("test_non_candidate_close: frame closed after %0d cycles", n);
  endtask

  task automatic test_overflow();
    logic [11:0] exp_x [4];
    exp_x[0] = 12'd0; exp_x[1] = 12'd6; exp_x[2] = 12'd12; exp_x[3] = 12'd18;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse_event(1'b1, 12'(3 * i), 12'd0);
      repeat (3) tick();
    end
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: overflow=%b want 1", o_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_det_valid !== 1'b1 || o_det_x !== exp_x[i] || o_det_y !== 12'd0) begin
        errors++; $display("FAIL ovf_drain%0d: v=%b x=%0d y=%0d want v=1 x=%0d y=0",
                           i, o_det_valid, o_det_x, o_det_y, exp_x[i]);
      end
      pop_one();
    end
    checks++;
    if (o_det_valid !== 1'b0 || o_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_empty: v=%b ovf=%b want v=0 ovf=1", o_det_valid, o_overflow);
    end
    $display("test_overflow: 5 events into 4 entries drained");
  endtask

  task automatic test_reset_midop();
    pulse_event(1'b1, 12'd2, 12'd3);
    tick();
    tick();
    checks++;
    if (o_det_valid !== 1'b1) begin
      errors++; $display("FAIL midop_pre: valid=%b want 1", o_det_valid);
    end
    pulse_event(1'b1, 12'd5, 12'd5);
    reset_fpga = 1'b1;
    tick();
    reset_fpga = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_det_valid !== 1'b0 || o_overflow !== 1'b0 || o_frame_count !== 12'd0) begin
        errors++; $display("FAIL midop%0d: v=%b ovf=%b cnt=%0d want 0 0 0", i, o_det_valid, o_overflow, o_frame_count);
      end
      tick();
    end
    $display("test_reset_midop: stored and in-flight entries discarded");
  endtask

  task automatic test_saturation();
    do_reset();
    pulse_event(1'b1, 12'd12, 12'd11);
    repeat (3) tick();
    pulse_event(1'b1, 12'd2, 12'd3);
    repeat (3) tick();
    checks++;
    if (o_det_valid !== 1'b1 || o_det_x !== 12'd19 || o_det_y !== 12'd15) begin
      errors++; $display("FAIL sat_head: v=%b x=%0d y=%0d want v=1 x=19 y=15", o_det_valid, o_det_x, o_det_y);
    end
    pop_one();
    checks++;
    if (o_det_valid !== 1'b1 || o_det_x !== 12'd4 || o_det_y !== 12'd4) begin
      errors++; $display("FAIL sat_second: v=%b x=%0d y=%0d want v=1 x=4 y=4", o_det_valid, o_det_x, o_det_y);
    end
    pop_one();
    $display("test_saturation: (12,11)->(19,15), (2,3)->(4,4)");
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_x [3];
    logic [11:0] exp_y [3];
    exp_x[0] = 12'd2;  exp_y[0] = 12'd1;
    exp_x[1] = 12'd10; exp_y[1] = 12'd7;
    exp_x[2] = 12'd18; exp_y[2] = 12'd13;
    do_reset();
    pulse_event(1'b1, 12'd1, 12'd1);
    pulse_event(1'b1, 12'd5, 12'd5);
    pulse_event(1'b1, 12'd9, 12'd9);
    repeat (6) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_det_valid !== 1'b1 || o_det_x !== exp_x[i] || o_det_y !== exp_y[i]) begin
        errors++; $display("FAIL b2b%0d: v=%b x=%0d y=%0d want v=1 x=%0d y=%0d",
                           i, o_det_valid, o_det_x, o_det_y, exp_x[i], exp_y[i]);
      end
      pop_one();
    end
    checks++;
    if (o_det_valid !== 1'b0 || o_overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_end: v=%b ovf=%b want 0 0", o_det_valid, o_overflow);
    end
    $display("test_back_to_back: 3 events 2 cycles apart via pending slot");
  endtask

  task automatic test_push_pop_empty();
    do_reset();
    det_ready = 1'b1;
    pulse_event(1'b1, 12'd3, 12'd2);
    tick();
    checks++;
    if (o_det_valid !== 1'b0) begin
      errors++; $display("FAIL ppe_early: valid=%b want 0", o_det_valid);
    end
    tick();
    checks++;
    if (o_det_valid !== 1'b1 || o_det_x !== 12'd6 || o_det_y !== 12'd3) begin
      errors++; $display("FAIL ppe_land: v=%b x=%0d y=%0d want v=1 x=6 y=3", o_det_valid, o_det_x, o_det_y);
    end
    tick();
    checks++;
    if (o_det_valid !== 1'b0) begin
      errors++; $display("FAIL ppe_popped: valid=%b want 0", o_det_valid);
    end
    det_ready = 1'b0;
    $display("test_push_pop_empty: entry (6,3) landed then popped");
  endtask

  task automatic test_merge_frame();
    int n;
    int exp_n;
    logic [11:0] exp_x [3];
    logic [11:0] exp_y [3];
`ifdef DETECTION_MERGE_EN
    exp_n = 2;
    exp_x[0] = 12'd8;  exp_y[0] = 12'd7;
    exp_x[1] = 12'd16; exp_y[1] = 12'd12;
    exp_x[2] = 12'd0;  exp_y[2] = 12'd0;
`else
    exp_n = 3;
    exp_x[0] = 12'd8;  exp_y[0] = 12'd7;
    exp_x[1] = 12'd10; exp_y[1] = 12'd7;
    exp_x[2] = 12'd16; exp_y[2] = 12'd12;
`endif
    do_reset();
    pulse_event(1'b1, 12'd4, 12'd5);
    pulse_event(1'b1, 12'd5, 12'd5);
    pulse_event(1'b1, 12'd8, 12'd8);
    pulse_frame_end();
    n = 0;
    while (o_frame_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (o_frame_done !== 1'b1) begin
      errors++; $display("FAIL merge_done: frame_done=%b want 1 within 20 cycles", o_frame_done);
    end else begin
      checks++;
      if (o_frame_count !== 12'(exp_n)) begin
        errors++; $display("FAIL merge_count: count=%0d want %0d", o_frame_count, exp_n);
      end
    end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (o_det_valid !== 1'b1 || o_det_x !== exp_x[i] || o_det_y !== exp_y[i]) begin
        errors++; $display("FAIL merge_entry%0d: v=%b x=%0d y=%0d want v=1 x=%0d y=%0d",
                           i, o_det_valid, o_det_x, o_det_y, exp_x[i], exp_y[i]);
      end
      pop_one();
    end
    checks++;
    if (o_det_valid !== 1'b0 || o_overflow !== 1'b0) begin
      errors++; $display("FAIL merge_end: v=%b ovf=%b want 0 0", o_det_valid, o_overflow);
    end
    $display("test_merge_frame: %0d entries expected, frame closed after %0d cycles", exp_n, n);
  endtask

  initial begin
    test_reset();
    test_latency_hold();
    test_non_candidate_close();
    test_overflow();
    test_reset_midop();
    test_saturation();
    test_back_to_back();
    test_push_pop_empty();
    test_merge_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
